dl_rom_sequencer: RTL and testbench
===================================

# dl_rom_sequencer

Sequences the byte stream from the SPI download port into the core's ROM write ports. It decodes each byte's address into one of four ROM regions and buffers writes in a small FIFO. Writes are issued to the target memory with a request/acknowledge handshake, and the core is held in reset for the whole download plus a fixed tail. It sits between `data_io` and the arcade core, replacing the direct `dn_addr`/`dn_data`/`dn_wr` wiring.

## Interface
Parameters:
- `AW`, 16: width of region-relative `mem_addr`.
- `R1_BASE`, 25'h04000: first byte address of region 1. Region 0 starts at 0.
- `R2_BASE`, 25'h05000: first byte address of region 2.
- `R3_BASE`, 25'h07000: first byte address of region 3.
- `TOP`, 25'h09000: first address past region 3. Bytes at or above `TOP` are discarded.
- `FIFO_DEPTH`, 4: FIFO entries. Must be a power of two, at least 2.
- `HOLD_CYCLES`, 1024: length of the reset tail after the download drains, at least 1.

Ports:
- `clk_sys` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `dl_active` in 1: download in progress (`ioctl_download`).
- `dl_wr` in 1: one-cycle byte strobe.
- `dl_addr` in 25: absolute byte address.
- `dl_data` in 8: byte.
- `mem_req` out 1: write request. Held until acknowledged.
- `mem_ack` in 1: target accepted the write in this cycle.
- `mem_sel` out 4: one-hot region select, valid while `mem_req` is high.
- `mem_addr` out AW: `dl_addr` minus the region base, truncated to AW bits.
- `mem_data` out 8: byte to write.
- `core_reset` out 1: reset to the arcade core.
- `busy` out 1: state is not IDLE.
- `overflow` out 1: sticky. A byte was lost because the FIFO was full.

## Operation
States: IDLE, LOAD, DRAIN, HOLD.

Reset behaviour (`reset` high):
- FIFO is flushed.
- `mem_req`=0, `mem_sel`=0, `mem_addr`=0, `mem_data`=0.
- `overflow`=0, `core_reset`=1, `busy`=1.
- State becomes HOLD with the tail counter at `HOLD_CYCLES`. Every power-up therefore gives the core a full reset tail.

State transitions:
- IDLE: `core_reset`=0. A high `dl_active` moves to LOAD.
- LOAD: `core_reset`=1. A falling `dl_active` moves to DRAIN.
- DRAIN: `core_reset`=1. When the FIFO is empty and `mem_req`=0, move to HOLD and load the counter with `HOLD_CYCLES`.
- HOLD: `core_reset`=1. The counter decrements each cycle; at 1, move to IDLE. A high `dl_active` in DRAIN or HOLD moves to LOAD; the FIFO keeps its contents and keeps draining.

Region decode (combinational on `dl_addr`):
- Below `R1_BASE`: region 0.
- Below `R2_BASE`: region 1.
- Below `R3_BASE`: region 2.
- Below `TOP`: region 3.
- Otherwise: the byte is discarded. It is never pushed and does not set `overflow`.

Push and drop rules:
- A byte is pushed only when `dl_wr` is high and the state is LOAD, or IDLE with `dl_active` high.
- If the FIFO is full and no pop happens in the same cycle, the byte is dropped and `overflow` is set.
- `overflow` clears on the next rising edge of `dl_active`.

Output stage:
- A registered slot sits after a first-word-fall-through FIFO.
- When the slot is empty, or is being acknowledged this cycle, and the FIFO is non-empty, the FIFO head loads the slot and is popped.
- `mem_req`, `mem_sel`, `mem_addr` and `mem_data` stay stable from the rise of `mem_req` until the cycle `mem_ack` is sampled high.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Latency: `dl_wr` in cycle t, with the FIFO and slot empty, gives `mem_req` high in cycle t+2.
- Throughput: with `mem_ack` held high, one write completes per cycle, with no bubble between back-to-back entries.
- Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
- Push and pop in the same cycle while empty: the byte goes through the FIFO and keeps the 2-cycle latency.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The occupancy counter is `log2(FIFO_DEPTH)+1` bits wide.
- `core_reset` rises in the cycle after `dl_active` is first sampled high.
- `core_reset` falls exactly `HOLD_CYCLES` cycles after the cycle in which DRAIN saw the FIFO empty and `mem_req`=0.
- `reset` asserted mid-transfer: `mem_req` drops on the next edge and any pending writes are lost.

## Test plan
- Release `reset` with `dl_active`=0 → `core_reset`=1 for 1024 cycles, then 0; `busy` follows; `mem_req` never rises.
- Pulse `dl_active` and write byte 0xA5 at 0x04010 with `mem_ack` tied high → `mem_req` 2 cycles later with `mem_sel`=4'b0010, `mem_addr`=0x0010, `mem_data`=0xA5, for exactly one cycle.
- Write bytes to 0x00000, 0x05000, 0x07FFF and 0x09000 → three writes with `mem_sel` 0001, 0100, 1000 and `mem_addr` 0x0000, 0x0000, 0x0FFF; the 0x09000 byte is never issued; `overflow`=0.
- Hold `mem_ack`=0 and issue 6 `dl_wr` pulses with `FIFO_DEPTH`=4 → the slot holds byte 1; bytes 2-5 fill the FIFO; byte 6 is dropped and `overflow`=1. Release ack → exactly 5 writes in order; `overflow` stays 1 until the next `dl_active` rise.
- Drop `dl_active` with 3 entries pending and ack every 3rd cycle → state stays DRAIN until the last ack, then HOLD; `core_reset` falls `HOLD_CYCLES` cycles later.
- Assert `reset` for one cycle while `mem_req` is high and the FIFO holds 2 entries → `mem_req`=0 the next cycle; no further writes issue; the HOLD tail restarts from 1024.

Source files
------------

// File: rtl/dl_rom_sequencer.sv
// dl_rom_sequencer: SPI download bytes -> region decode -> FIFO -> ROM write port.
// Ports: clk_sys/reset, dl_* download in, mem_* req/ack write out, core_reset/busy/overflow.
module dl_rom_sequencer #(
  parameter int          AW          = 16,
  parameter logic [24:0] R1_BASE     = 25'h04000,
  parameter logic [24:0] R2_BASE     = 25'h05000,
  parameter logic [24:0] R3_BASE     = 25'h07000,
  parameter logic [24:0] TOP         = 25'h09000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [3:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data,
  output logic          core_reset,
  output logic          busy,
  output logic          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int EW = 2 + AW + 8;

  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          act_q;

  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;

  logic          in_range;
  logic [1:0]    region;
  logic [24:0]   base;
  logic [AW-1:0] rel_addr;

  logic can_load;
  logic want;
  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    in_range = 1'b1;
    region   = 2'd0;
    base     = '0;
    if (dl_addr < R1_BASE) begin
      region = 2'd0;
      base   = '0;
    end else if (dl_addr < R2_BASE) begin
      region = 2'd1;
      base   = R1_BASE;
    end else if (dl_addr < R3_BASE) begin
      region = 2'd2;
      base   = R2_BASE;
    end else if (dl_addr < TOP) begin
      region = 2'd3;
      base   = R3_BASE;
    end else begin
      in_range = 1'b0;
    end
  end

  assign rel_addr = AW'(dl_addr - base);

  // IDLE accepts bytes in the same cycle dl_active is first seen.
  assign can_load = (state == S_LOAD) ||
                    ((state == S_IDLE) && dl_active);
  assign want  = dl_wr && in_range && can_load;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // Slot refills in the same cycle it is acknowledged: no bubble.
  assign pop   = !empty && (!mem_req || mem_ack);
  assign push  = want && (!full || pop);
  assign drop  = want && full && !pop;
  assign head  = fifo[rd_ptr];

  assign busy       = (state != S_IDLE);
  assign core_reset = busy;

  always_ff @(posedge clk_sys) begin
    if (push) fifo[wr_ptr] <= {region, rel_addr, dl_data};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= S_HOLD;
      hold_cnt <= HOLD_INIT;
      act_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_req  <= 1'b0;
      mem_sel  <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      overflow <= 1'b0;
    end else begin
      act_q <= dl_active;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (pop) begin
        mem_req  <= 1'b1;
        mem_sel  <= 4'b0001 << head[EW-1 -: 2];
        mem_addr <= head[8 +: AW];
        mem_data <= head[7:0];
      end else if (mem_ack) begin
        mem_req <= 1'b0;
      end

      if (drop)                    overflow <= 1'b1;
      else if (dl_active && !act_q) overflow <= 1'b0;

      unique case (state)
        S_IDLE: if (dl_active) state <= S_LOAD;
        S_LOAD: if (!dl_active) state <= S_DRAIN;
        S_DRAIN: begin
          if (dl_active) begin
            state <= S_LOAD;
          end else if (empty && !mem_req) begin
            state    <= S_HOLD;
            hold_cnt <= HOLD_INIT;
          end
        end
        S_HOLD: begin
          if (dl_active)               state <= S_LOAD;
          else if (hold_cnt == HW'(1)) state <= S_IDLE;
          else                         hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_rom_sequencer.sv
// tb_dl_rom_sequencer: directed + randomized checks of dl_rom_sequencer
// against an address-map model and an expected-write queue.
module tb_dl_rom_sequencer;

  localparam int AW   = 16;
  localparam int HOLD = 1024;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          dl_active = 1'b0;
  logic          dl_wr = 1'b0;
  logic [24:0]   dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          mem_ack = 1'b0;
  logic          mem_req;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          core_reset;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int failures = 0;
  wr_t exp_q[$];

  always #5 clk_sys = ~clk_sys;

  dl_rom_sequencer dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_data(mem_data), .core_reset(core_reset),
    .busy(busy), .overflow(overflow)
  );

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Address map model: region windows straight from the memory map.
  function automatic bit ref_map(input logic [24:0] a,
                                 input logic [7:0] d,
                                 output wr_t w);
    int unsigned x;
    x = a;
    w.data = d;
    w.sel = '0;
    w.addr = '0;
    if (x < 32'h4000) begin
      w.sel = 4'b0001; w.addr = 16'(x);
    end else if (x < 32'h5000) begin
      w.sel = 4'b0010; w.addr = 16'(x - 32'h4000);
    end else if (x < 32'h7000) begin
      w.sel = 4'b0100; w.addr = 16'(x - 32'h5000);
    end else if (x < 32'h9000) begin
      w.sel = 4'b1000; w.addr = 16'(x - 32'h7000);
    end else begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    dl_active = 0;
    dl_wr = 0;
    mem_ack = 1;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy=%0b after %0d cycles, required 0",
               busy, n);
    end
  endtask

  task automatic test_reset();
    int n;
    bit req_seen;
    bit busy_bad;
    n = 0;
    req_seen = 0;
    busy_bad = 0;
    reset = 1;
    dl_active = 0;
    mem_ack = 0;
    step();
    step();
    reset = 0;
    checks++;
    if (mem_req !== 0 || mem_sel !== 0 || mem_addr !== 0 ||
        mem_data !== 0 || overflow !== 0) begin
      failures++;
      $display("FAIL reset_outs req=%b sel=%h addr=%h data=%h ovf=%b, required all 0",
               mem_req, mem_sel, mem_addr, mem_data, overflow);
    end
    while (core_reset === 1'b1 && n < 2000) begin
      if (mem_req !== 1'b0) req_seen = 1;
      if (busy !== core_reset) busy_bad = 1;
      step();
      n++;
    end
    checks++;
    if (n != HOLD) begin
      failures++;
      $display("FAIL reset_tail core_reset high %0d cycles, required %0d",
               n, HOLD);
    end
    checks++;
    if (req_seen) begin
      failures++;
      $display("FAIL reset_req mem_req rose during tail, required never");
    end
    checks++;
    if (busy_bad || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy busy=%b mismatched core_reset, required equal",
               busy);
    end
  endtask

  task automatic test_single();
    mem_ack = 1;
    dl_active = 1;
    dl_wr = 1;
    dl_addr = 25'h04010;
    dl_data = 8'hA5;
    step();
    dl_wr = 0;
    checks++;
    if (mem_req !== 0 || core_reset !== 1) begin
      failures++;
      $display("FAIL single_t1 req=%b core_reset=%b, required 0/1",
               mem_req, core_reset);
    end
    step();
    checks++;
    if (mem_req !== 1 || mem_sel !== 4'b0010 ||
        mem_addr !== 16'h0010 || mem_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_t2 req=%b sel=%b addr=%h data=%h, required 1/0010/0010/a5",
               mem_req, mem_sel, mem_addr, mem_data);
    end
    step();
    checks++;
    if (mem_req !== 0) begin
      failures++;
      $display("FAIL single_t3 req=%b, required 0", mem_req);
    end
    wait_idle();
  endtask

  task automatic test_regions();
    logic [24:0] a [4];
    logic [3:0]  es [3];
    logic [15:0] ea [3];
    logic [7:0]  d [4];
    wr_t got [$];
    wr_t w;
    a[0] = 25'h00000; a[1] = 25'h05000;
    a[2] = 25'h07FFF; a[3] = 25'h09000;
    es[0] = 4'b0001; es[1] = 4'b0100; es[2] = 4'b1000;
    ea[0] = 16'h0000; ea[1] = 16'h0000; ea[2] = 16'h0FFF;
    for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
    mem_ack = 1;
    dl_active = 1;
    for (int i = 0; i < 14; i++) begin
      if (i < 4) begin
        dl_wr = 1; dl_addr = a[i]; dl_data = d[i];
      end else begin
        dl_wr = 0;
      end
      if (mem_req === 1'b1) begin
        w.sel = mem_sel; w.addr = mem_addr; w.data = mem_data;
        got.push_back(w);
      end
      step();
    end
    checks++;
    if (got.size() != 3) begin
      failures++;
      $display("FAIL regions_count writes=%0d, required 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i].sel !== es[i] || got[i].addr !== ea[i] ||
          got[i].data !== d[i]) begin
        failures++;
        $display("FAIL regions_w%0d sel=%b addr=%h data=%h, required %b/%h/%h",
                 i, got[i].sel, got[i].addr, got[i].data,
                 es[i], ea[i], d[i]);
      end
    end
    checks++;
    if (overflow !== 0) begin
      failures++;
      $display("FAIL regions_ovf overflow=%b, required 0", overflow);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    wr_t w;
    int cyc [$];
    mem_ack = 1;
    dl_active = 1;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      if (i < 4) begin
        dl_wr = 1;
        dl_addr = 25'($urandom_range(0, 32'h8FFF));
        dl_data = 8'($urandom);
        void'(ref_map(dl_addr, dl_data, w));
        exp_q.push_back(w);
      end else begin
        dl_wr = 0;
      end
      if (mem_req === 1'b1) begin
        cyc.push_back(i);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra write at cycle %0d, required none", i);
        end else begin
          w = exp_q.pop_front();
          if (mem_sel !== w.sel || mem_addr !== w.addr ||
              mem_data !== w.data) begin
            failures++;
            $display("FAIL b2b_data sel=%b addr=%h data=%h, required %b/%h/%h",
                     mem_sel, mem_addr, mem_data, w.sel, w.addr, w.data);
          end
        end
      end
      step();
    end
    checks++;
    if (cyc.size() != 4 || cyc[0] != 2 || cyc[3] != 5) begin
      failures++;
      $display("FAIL b2b_timing writes=%0d, required 4 in cycles 2..5",
               cyc.size());
    end
    wait_idle();
  endtask

  task automatic test_overflow();
    logic [7:0] d [6];
    int n;
    bit unstable;
    n = 0;
    unstable = 0;
    mem_ack = 0;
    dl_active = 1;
    for (int i = 0; i < 6; i++) begin
      d[i] = 8'($urandom);
      dl_wr = 1;
      dl_addr = 25'h00100 + 25'(i);
      dl_data = d[i];
      step();
    end
    dl_wr = 0;
    checks++;
    if (overflow !== 1 || mem_req !== 1 || mem_data !== d[0]) begin
      failures++;
      $display("FAIL ovf_full ovf=%b req=%b data=%h, required 1/1/%h",
               overflow, mem_req, mem_data, d[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (mem_req !== 1 || mem_addr !== 16'h0100 || mem_data !== d[0])
        unstable = 1;
    end
    checks++;
    if (unstable) begin
      failures++;
      $display("FAIL ovf_hold slot changed without ack, required stable %h",
               d[0]);
    end
    mem_ack = 1;
    for (int i = 0; i < 10; i++) begin
      if (mem_req === 1'b1) begin
        checks++;
        if (n >= 5 || mem_data !== d[n] ||
            mem_addr !== 16'h0100 + 16'(n) || mem_sel !== 4'b0001) begin
          failures++;
          $display("FAIL ovf_order write %0d data=%h addr=%h, required %0d writes in order",
                   n, mem_data, mem_addr, 5);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL ovf_count writes=%0d, required 5", n);
    end
    wait_idle();
    checks++;
    if (overflow !== 1) begin
      failures++;
      $display("FAIL ovf_sticky overflow=%b, required 1", overflow);
    end
    dl_active = 1;
    step();
    checks++;
    if (overflow !== 0) begin
      failures++;
      $display("FAIL ovf_clear overflow=%b after dl_active rise, required 0",
               overflow);
    end
    wait_idle();
  endtask

  task automatic test_drain();
    logic [7:0] d [3];
    int acks;
    int n;
    bit early;
    acks = 0;
    n = 0;
    early = 0;
    mem_ack = 0;
    dl_active = 1;
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'($urandom);
      dl_wr = 1;
      dl_addr = 25'h05200 + 25'(i);
      dl_data = d[i];
      step();
    end
    dl_wr = 0;
    dl_active = 0;
    for (int k = 0; k < 60 && acks < 3; k++) begin
      mem_ack = (k % 3 == 2);
      if (core_reset !== 1'b1) early = 1;
      if (mem_req === 1'b1 && mem_ack) begin
        checks++;
        if (mem_data !== d[acks] || mem_sel !== 4'b0100 ||
            mem_addr !== 16'h0200 + 16'(acks)) begin
          failures++;
          $display("FAIL drain_w%0d data=%h addr=%h, required %h/%h",
                   acks, mem_data, mem_addr, d[acks],
                   16'h0200 + 16'(acks));
        end
        acks++;
      end
      step();
    end
    mem_ack = 0;
    checks++;
    if (acks != 3 || early) begin
      failures++;
      $display("FAIL drain_acks acks=%0d early_release=%b, required 3/0",
               acks, early);
    end
    while (core_reset === 1'b1 && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("FAIL drain_tail core_reset high %0d cycles after last ack, required %0d",
               n, HOLD + 1);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
    bit req_seen;
    n = 0;
    req_seen = 0;
    mem_ack = 0;
    dl_active = 1;
    for (int i = 0; i < 3; i++) begin
      dl_wr = 1;
      dl_addr = 25'h00020 + 25'(i);
      dl_data = 8'($urandom);
      step();
    end
    dl_wr = 0;
    checks++;
    if (mem_req !== 1) begin
      failures++;
      $display("FAIL rmid_pre req=%b, required 1", mem_req);
    end
    reset = 1;
    step();
    reset = 0;
    dl_active = 0;
    mem_ack = 1;
    checks++;
    if (mem_req !== 0) begin
      failures++;
      $display("FAIL rmid_drop req=%b after reset, required 0", mem_req);
    end
    while (core_reset === 1'b1 && n < 3000) begin
      if (mem_req !== 1'b0) req_seen = 1;
      step();
      n++;
    end
    checks++;
    if (n != HOLD || req_seen) begin
      failures++;
      $display("FAIL rmid_tail tail=%0d req_seen=%b, required %0d/0",
               n, req_seen, HOLD);
    end
  endtask

  task automatic test_random();
    int issued;
    int cyc;
    wr_t w;
    logic [AW+12:0] prev;
    bit prev_hold;
    issued = 0;
    cyc = 0;
    prev = '0;
    prev_hold = 0;
    exp_q.delete();
    dl_active = 1;
    while ((issued < 80 || exp_q.size() != 0) && cyc < 4000) begin
      if (issued < 80 && exp_q.size() < 4 &&
          $urandom_range(0, 2) != 0) begin
        dl_wr = 1;
        dl_addr = 25'($urandom_range(0, 32'h9800));
        dl_data = 8'($urandom);
        issued++;
        if (ref_map(dl_addr, dl_data, w)) exp_q.push_back(w);
      end else begin
        dl_wr = 0;
      end
      mem_ack = ($urandom_range(0, 1) == 1);
      if (prev_hold) begin
        checks++;
        if ({mem_req, mem_sel, mem_addr, mem_data} !== prev) begin
          failures++;
          $display("FAIL rand_stable got %h, required %h",
                   {mem_req, mem_sel, mem_addr, mem_data}, prev);
        end
      end
      if (mem_req === 1'b1 && mem_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra sel=%b addr=%h data=%h, required no write",
                   mem_sel, mem_addr, mem_data);
        end else begin
          w = exp_q.pop_front();
          if (mem_sel !== w.sel || mem_addr !== w.addr ||
              mem_data !== w.data) begin
            failures++;
            $display("FAIL rand_write sel=%b addr=%h data=%h, required %b/%h/%h",
                     mem_sel, mem_addr, mem_data, w.sel, w.addr, w.data);
          end
        end
      end
      prev_hold = (mem_req === 1'b1) && !mem_ack;
      prev = {mem_req, mem_sel, mem_addr, mem_data};
      step();
      cyc++;
    end
    dl_wr = 0;
    checks++;
    if (exp_q.size() != 0 || overflow !== 0) begin
      failures++;
      $display("FAIL rand_done pending=%0d ovf=%b, required 0/0",
               exp_q.size(), overflow);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_regions();
    test_back_to_back();
    test_overflow();
    test_drain();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
